// File: rtl/axi_r_router_if.sv
// Read-data bundle between the R-channel router, its slave ports and the two masters.
// The router uses the slave view; the master view drives slave beats and master readies.
interface axi_r_router_if #(
    parameter int NS        = 6,
    parameter int ID_BITS   = 4,
    parameter int IDS_BITS  = 8,
    parameter int DATA_BITS = 32
);
    logic [NS*IDS_BITS-1:0]  RID_S;
    logic [NS*DATA_BITS-1:0] RDATA_S;
    logic [NS*2-1:0]         RRESP_S;
    logic [NS-1:0]           RLAST_S;
    logic [NS-1:0]           RVALID_S;
    logic [NS-1:0]           RREADY_S;

    logic [ID_BITS-1:0]      RID_M0;
    logic [DATA_BITS-1:0]    RDATA_M0;
    logic [1:0]              RRESP_M0;
    logic                    RLAST_M0;
    logic                    RVALID_M0;
    logic                    RREADY_M0;

    logic [ID_BITS-1:0]      RID_M1;
    logic [DATA_BITS-1:0]    RDATA_M1;
    logic [1:0]              RRESP_M1;
    logic                    RLAST_M1;
    logic                    RVALID_M1;
    logic                    RREADY_M1;

    modport slave (
        input  RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
        output RREADY_S,
        output RID_M0, RDATA_M0, RRESP_M0, RLAST_M0, RVALID_M0,
        input  RREADY_M0,
        output RID_M1, RDATA_M1, RRESP_M1, RLAST_M1, RVALID_M1,
        input  RREADY_M1
    );

    modport master (
        output RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
        input  RREADY_S,
        input  RID_M0, RDATA_M0, RRESP_M0, RLAST_M0, RVALID_M0,
        output RREADY_M0,
        input  RID_M1, RDATA_M1, RRESP_M1, RLAST_M1, RVALID_M1,
        output RREADY_M1
    );
endinterface

// File: rtl/axi_r_router.sv
// AXI read-data return router: steers slave R beats to M0/M1 by the master index in RID's upper bits.
// One round-robin grant FSM per master; a grant is held until the burst's RLAST handshake.
module axi_r_router #(
    parameter int NS        = 6,
    parameter int ID_BITS   = 4,
    parameter int IDS_BITS  = 8,
    parameter int DATA_BITS = 32
) (
    input  logic           clk,
    input  logic           rst,
    axi_r_router_if.slave  bus
);
    localparam int GW = $clog2(NS);
    localparam int TW = IDS_BITS - ID_BITS;
    localparam int NM = 2;

    typedef enum logic {IDLE, BUSY} state_t;

    logic [IDS_BITS-1:0]  rid_s   [NS];
    logic [DATA_BITS-1:0] rdata_s [NS];
    logic [1:0]           rresp_s [NS];
    logic [TW-1:0]        tgt_s   [NS];
    logic [NS-1:0]        rvalid_s;
    logic [NS-1:0]        rlast_s;
    logic [NS-1:0]        rready_s;

    logic [NM-1:0]                busy_m;
    logic [NM-1:0]                rready_m;
    logic [NM-1:0]                rvalid_m;
    logic [NM-1:0]                rlast_m;
    logic [NM-1:0][GW-1:0]        grant_m;
    logic [NM-1:0][ID_BITS-1:0]   rid_m;
    logic [NM-1:0][DATA_BITS-1:0] rdata_m;
    logic [NM-1:0][1:0]           rresp_m;

    assign rvalid_s = bus.RVALID_S;
    assign rlast_s  = bus.RLAST_S;
    assign rready_m = {bus.RREADY_M1, bus.RREADY_M0};

    genvar gi;
    generate
        for (gi = 0; gi < NS; gi++) begin : g_slave
            logic granted;
            logic illegal;

            assign rid_s[gi]   = bus.RID_S[gi*IDS_BITS +: IDS_BITS];
            assign rdata_s[gi] = bus.RDATA_S[gi*DATA_BITS +: DATA_BITS];
            assign rresp_s[gi] = bus.RRESP_S[gi*2 +: 2];
            assign tgt_s[gi]   = rid_s[gi][IDS_BITS-1:ID_BITS];

            assign granted = (busy_m[0] && (grant_m[0] == GW'(gi)))
                          || (busy_m[1] && (grant_m[1] == GW'(gi)));
            assign illegal = (tgt_s[gi] >= TW'(NM));

            // Beats addressed to no master are sunk here so the slave can run to RLAST.
            assign rready_s[gi] = rst && (
                   (busy_m[0] && (grant_m[0] == GW'(gi)) && rready_m[0])
                || (busy_m[1] && (grant_m[1] == GW'(gi)) && rready_m[1])
                || (rvalid_s[gi] && illegal && !granted));
        end

        for (gi = 0; gi < NM; gi++) begin : g_master
            state_t          state_reg;
            logic [GW-1:0]   grant_reg;
            logic [GW-1:0]   ptr_reg;
            logic [GW-1:0]   pick;
            logic [GW:0]     sum;
            logic [NS-1:0]   req;
            logic            found;

            // Search starts at ptr_reg and wraps modulo NS; first requester wins.
            always_comb begin
                req   = '0;
                pick  = '0;
                sum   = '0;
                found = 1'b0;
                for (int i = 0; i < NS; i++) begin
                    req[i] = rvalid_s[i] && (tgt_s[i] == TW'(gi));
                end
                for (int k = 0; k < NS; k++) begin
                    sum = {1'b0, ptr_reg} + (GW+1)'(k);
                    if (sum >= (GW+1)'(NS)) begin
                        sum = sum - (GW+1)'(NS);
                    end
                    if (!found && req[sum[GW-1:0]]) begin
                        found = 1'b1;
                        pick  = sum[GW-1:0];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!rst) begin
                    state_reg <= IDLE;
                    grant_reg <= '0;
                    ptr_reg   <= '0;
                end else begin
                    case (state_reg)
                        IDLE: begin
                            if (found) begin
                                grant_reg <= pick;
                                state_reg <= BUSY;
                            end
                        end
                        BUSY: begin
                            if (rvalid_s[grant_reg] && rready_m[gi] && rlast_s[grant_reg]) begin
                                state_reg <= IDLE;
                                ptr_reg   <= (grant_reg == GW'(NS-1)) ? '0 : grant_reg + 1'b1;
                            end
                        end
                        default: state_reg <= IDLE;
                    endcase
                end
            end

            // Reset also blocks the pass-through so no beat is consumed while rst is low.
            assign busy_m[gi]   = rst && (state_reg == BUSY);
            assign grant_m[gi]  = grant_reg;
            assign rvalid_m[gi] = busy_m[gi] && rvalid_s[grant_reg];
            assign rlast_m[gi]  = busy_m[gi] && rlast_s[grant_reg];
            assign rid_m[gi]    = busy_m[gi] ? rid_s[grant_reg][ID_BITS-1:0] : '0;
            assign rdata_m[gi]  = busy_m[gi] ? rdata_s[grant_reg] : '0;
            assign rresp_m[gi]  = busy_m[gi] ? rresp_s[grant_reg] : '0;
        end
    endgenerate

    assign bus.RREADY_S  = rready_s;

    assign bus.RID_M0    = rid_m[0];
    assign bus.RDATA_M0  = rdata_m[0];
    assign bus.RRESP_M0  = rresp_m[0];
    assign bus.RLAST_M0  = rlast_m[0];
    assign bus.RVALID_M0 = rvalid_m[0];

    assign bus.RID_M1    = rid_m[1];
    assign bus.RDATA_M1  = rdata_m[1];
    assign bus.RRESP_M1  = rresp_m[1];
    assign bus.RLAST_M1  = rlast_m[1];
    assign bus.RVALID_M1 = rvalid_m[1];
endmodule

// File: tb/tb_axi_r_router.sv
// Directed bench for axi_r_router: a table of single bursts plus hand-written
// parallel, round-robin, stall and reset sequences, scored against per-master queues.
module tb_axi_r_router;
    localparam int NS = 6;
    localparam int ID_BITS = 4;
    localparam int IDS_BITS = 8;
    localparam int DATA_BITS = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    axi_r_router_if #(.NS(NS), .ID_BITS(ID_BITS), .IDS_BITS(IDS_BITS), .DATA_BITS(DATA_BITS)) bus ();

    axi_r_router #(.NS(NS), .ID_BITS(ID_BITS), .IDS_BITS(IDS_BITS), .DATA_BITS(DATA_BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    typedef struct {
        int         slv;
        logic [7:0] rid;
        int         beats;
        logic [1:0] resp;
        int         exp_m;
        logic [3:0] exp_id;
    } vec_t;

    int checks = 0;
    int errors = 0;

    int         s_cnt  [NS];
    int         s_beat [NS];
    int         s_tag  [NS];
    logic [7:0] s_rid  [NS];
    logic [1:0] s_resp [NS];
    logic [NS-1:0] hs;

    beat_t exp_q0[$];
    beat_t exp_q1[$];
    vec_t  vecs[6];

    function automatic logic [31:0] mkdata(int s, int tag, int b);
        return 32'hD000_0000 | (32'(s) << 16) | (32'(tag) << 8) | 32'(b);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_slaves();
        for (int i = 0; i < NS; i++) begin
            bus.RVALID_S[i] = (s_cnt[i] > 0);
            bus.RLAST_S[i] = (s_cnt[i] == 1);
            bus.RID_S[i*IDS_BITS +: IDS_BITS] = s_rid[i];
            bus.RDATA_S[i*DATA_BITS +: DATA_BITS] = mkdata(i, s_tag[i], s_beat[i]);
            bus.RRESP_S[i*2 +: 2] = s_resp[i];
        end
    endtask

    task automatic push_burst(input int s, input logic [7:0] rid, input int n, input logic [1:0] resp,
                              input int tag, input int m, input logic [3:0] eid);
        beat_t e;
        s_cnt[s] = n;
        s_beat[s] = 0;
        s_rid[s] = rid;
        s_resp[s] = resp;
        s_tag[s] = tag;
        for (int b = 0; b < n; b++) begin
            e.id = eid;
            e.data = mkdata(s, tag, b);
            e.resp = resp;
            e.last = (b == n - 1);
            if (m == 0) exp_q0.push_back(e);
            else if (m == 1) exp_q1.push_back(e);
        end
        drive_slaves();
    endtask

    task automatic mon(input int m, input logic v, input logic r, input logic [3:0] id,
                       input logic [31:0] d, input logic [1:0] resp, input logic last);
        beat_t e;
        int sz;
        sz = (m == 0) ? exp_q0.size() : exp_q1.size();
        if (sz == 0) begin
            chk((m == 0) ? "m0_spurious_valid" : "m1_spurious_valid", v, 1'b0);
        end else if (v && r) begin
            if (m == 0) e = exp_q0.pop_front();
            else e = exp_q1.pop_front();
            chk((m == 0) ? "m0_beat" : "m1_beat", {id, d, resp, last}, {e.id, e.data, e.resp, e.last});
            $display("M%0d beat id=%h data=%h resp=%b last=%b", m, id, d, resp, last);
        end
    endtask

    task automatic negedge_sample();
        @(negedge clk);
        hs = bus.RVALID_S & bus.RREADY_S;
        mon(0, bus.RVALID_M0, bus.RREADY_M0, bus.RID_M0, bus.RDATA_M0, bus.RRESP_M0, bus.RLAST_M0);
        mon(1, bus.RVALID_M1, bus.RREADY_M1, bus.RID_M1, bus.RDATA_M1, bus.RRESP_M1, bus.RLAST_M1);
    endtask

    task automatic posedge_advance();
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) begin
            if (hs[i]) begin
                s_cnt[i]--;
                s_beat[i]++;
            end
        end
        drive_slaves();
    endtask

    task automatic cycle();
        negedge_sample();
        posedge_advance();
    endtask

    function automatic int pending();
        int p = 0;
        for (int i = 0; i < NS; i++) p += s_cnt[i];
        return p + exp_q0.size() + exp_q1.size();
    endfunction

    task automatic run_until_idle(input string name);
        int n = 0;
        while (pending() != 0 && n < 200) begin
            cycle();
            n++;
        end
        chk(name, pending(), 0);
    endtask

    task automatic idle_check(input string name);
        negedge_sample();
        chk(name, {bus.RVALID_M0, bus.RLAST_M0, bus.RID_M0, bus.RRESP_M0,
                   bus.RVALID_M1, bus.RLAST_M1, bus.RID_M1, bus.RRESP_M1,
                   bus.RDATA_M0 | bus.RDATA_M1}, 48'h0);
        posedge_advance();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{slv: 0, rid: 8'h03, beats: 4, resp: 2'b00, exp_m: 0,  exp_id: 4'h3};
        vecs[1] = '{slv: 1, rid: 8'h1A, beats: 2, resp: 2'b01, exp_m: 1,  exp_id: 4'hA};
        vecs[2] = '{slv: 5, rid: 8'h0F, beats: 1, resp: 2'b11, exp_m: 0,  exp_id: 4'hF};
        vecs[3] = '{slv: 2, rid: 8'h27, beats: 2, resp: 2'b00, exp_m: -1, exp_id: 4'h0};
        vecs[4] = '{slv: 3, rid: 8'h1C, beats: 3, resp: 2'b10, exp_m: 1,  exp_id: 4'hC};
        vecs[5] = '{slv: 4, rid: 8'h72, beats: 2, resp: 2'b00, exp_m: -1, exp_id: 4'h0};

        for (int i = 0; i < NS; i++) begin
            s_cnt[i] = 0; s_beat[i] = 0; s_tag[i] = 0; s_rid[i] = 8'h00; s_resp[i] = 2'b00;
        end
        bus.RREADY_M0 = 1'b1;
        bus.RREADY_M1 = 1'b1;
        drive_slaves();

        // Reset: even an illegal-target beat must not be accepted.
        push_burst(4, 8'h30, 1, 2'b00, 1, -1, 4'h0);
        cycle();
        cycle();
        negedge_sample();
        chk("reset_rready", bus.RREADY_S, 6'b000000);
        chk("reset_outs", {bus.RVALID_M0, bus.RVALID_M1, bus.RLAST_M0, bus.RLAST_M1,
                           bus.RID_M0, bus.RID_M1, bus.RDATA_M0, bus.RDATA_M1}, 0);
        posedge_advance();
        rst = 1'b1;
        negedge_sample();
        chk("post_reset_drain", bus.RREADY_S, 6'b010000);
        posedge_advance();
        run_until_idle("reset_drain_done");
        idle_check("reset_idle");

        // Single-burst table: latency, routing, drain.
        for (int v = 0; v < 6; v++) begin
            push_burst(vecs[v].slv, vecs[v].rid, vecs[v].beats, vecs[v].resp, 10 + v,
                       vecs[v].exp_m, vecs[v].exp_id);
            negedge_sample();
            chk("vec_idle_valid", {bus.RVALID_M1, bus.RVALID_M0}, 2'b00);
            chk("vec_drain_ready", bus.RREADY_S[vecs[v].slv], (vecs[v].exp_m < 0));
            posedge_advance();
            if (vecs[v].exp_m >= 0) begin
                negedge_sample();
                chk("vec_first_beat", (vecs[v].exp_m == 0) ? bus.RVALID_M0 : bus.RVALID_M1, 1'b1);
                posedge_advance();
            end
            run_until_idle("vec_done");
            idle_check("vec_idle_after");
        end

        // Two masters in parallel: S1 -> M1, S2 -> M0.
        push_burst(1, 8'h12, 3, 2'b00, 20, 1, 4'h2);
        push_burst(2, 8'h05, 3, 2'b01, 21, 0, 4'h5);
        cycle();
        negedge_sample();
        chk("par_both_valid", {bus.RVALID_M1, bus.RVALID_M0}, 2'b11);
        posedge_advance();
        run_until_idle("par_done");
        idle_check("par_idle");

        // Stall on SDEFAULT with RRESP=11: ready pattern 1,0,0,1.
        push_burst(5, 8'h0E, 4, 2'b11, 40, 0, 4'hE);
        cycle();
        negedge_sample();
        chk("stall_first_valid", bus.RVALID_M0, 1'b1);
        posedge_advance();
        bus.RREADY_M0 = 1'b0;
        for (int c = 0; c < 2; c++) begin
            negedge_sample();
            chk("stall_ready_low", bus.RREADY_S[5], 1'b0);
            chk("stall_data_held", {bus.RVALID_M0, bus.RDATA_M0, bus.RRESP_M0},
                {1'b1, mkdata(5, 40, 1), 2'b11});
            posedge_advance();
        end
        bus.RREADY_M0 = 1'b1;
        negedge_sample();
        chk("stall_resume_ready", bus.RREADY_S[5], 1'b1);
        posedge_advance();
        run_until_idle("stall_done");
        idle_check("stall_idle");

        // Round robin for M0 from p=0: S0,S3,S4, then wrap S0 before S3.
        push_burst(0, 8'h01, 2, 2'b00, 30, 0, 4'h1);
        push_burst(3, 8'h02, 2, 2'b00, 31, 0, 4'h2);
        push_burst(4, 8'h03, 2, 2'b00, 32, 0, 4'h3);
        run_until_idle("rr1_done");
        idle_check("rr1_idle");
        push_burst(0, 8'h04, 2, 2'b00, 33, 0, 4'h4);
        push_burst(3, 8'h05, 2, 2'b00, 34, 0, 4'h5);
        run_until_idle("rr2_done");
        idle_check("rr2_idle");

        // Reset during the second beat of an S3 burst; S4 waits for M0.
        push_burst(3, 8'h06, 4, 2'b00, 50, 0, 4'h6);
        cycle();
        cycle();
        push_burst(4, 8'h07, 2, 2'b00, 51, 0, 4'h7);
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        negedge_sample();
        chk("rst_all_idle", {bus.RVALID_M1, bus.RVALID_M0}, 2'b00);
        posedge_advance();
        negedge_sample();
        chk("rst_regrant", {bus.RVALID_M0, bus.RDATA_M0}, {1'b1, mkdata(3, 50, 1)});
        posedge_advance();
        run_until_idle("rst_done");
        idle_check("rst_idle_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
